// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and
// the bundle of registered sequencer outputs.
package cpu_pkg;

   localparam logic [4:0] OP_ADD   = 5'b00000;
   localparam logic [4:0] OP_SUB   = 5'b00001;
   localparam logic [4:0] OP_AND   = 5'b00010;
   localparam logic [4:0] OP_OR    = 5'b00011;
   localparam logic [4:0] OP_LOAD  = 5'b01000;
   localparam logic [4:0] OP_STORE = 5'b01001;
   localparam logic [4:0] OP_JMP   = 5'b01100;
   localparam logic [4:0] OP_BZ    = 5'b01101;
   localparam logic [4:0] OP_NOP   = 5'b11110;
   localparam logic [4:0] OP_HLT   = 5'b11111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   typedef struct packed {
      logic t1;
      logic t2;
      logic t3;
      logic t4;
      logic ir_load;
      logic pc_inc;
      logic mem_req;
      logic mem_we;
      logic reg_we;
      logic halted;
      logic bus_err;
   } outs_t;

   function automatic logic [4:0] opcode_of(input logic [15:0] ir);
      return ir[15:11];
   endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode classifier; anything not recognised falls out with
// every class low and therefore behaves as a NOP.
module seq_decode
   import cpu_pkg::*;
(
   input  logic [4:0] opcode,
   output logic       is_alu,
   output logic       is_load,
   output logic       is_store,
   output logic       is_jmp,
   output logic       is_bz,
   output logic       is_hlt
);

   assign is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   assign is_jmp   = (opcode == OP_JMP);
   assign is_bz    = (opcode == OP_BZ);
   assign is_hlt   = (opcode == OP_HLT);

endmodule

// File: rtl/cpu_seq.sv
// Instruction sequencer: steps FETCH/DECODE/EXEC/MEM/WB, raises the beat and
// datapath strobes, and halts on HLT or on a memory that never answers.
module cpu_seq
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        step,
   input  logic [15:0] ir,
   input  logic        zf,
   input  logic        mem_ack,
   output logic        T1,
   output logic        T2,
   output logic        T3,
   output logic        T4,
   output logic        ir_load,
   output logic        pc_inc,
   output logic        pc_load,
   output logic        mem_req,
   output logic        mem_we,
   output logic        reg_we,
   output logic        halted,
   output logic        bus_err
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_nxt;
   outs_t         o, o_nxt;
   logic          ready;
   logic          waiting;
   logic          is_alu, is_load, is_store, is_jmp, is_bz, is_hlt;
   logic          unused_ir_fields;

   assign unused_ir_fields = ^ir[10:0];

   seq_decode u_decode (
      .opcode   (opcode_of(ir)),
      .is_alu   (is_alu),
      .is_load  (is_load),
      .is_store (is_store),
      .is_jmp   (is_jmp),
      .is_bz    (is_bz),
      .is_hlt   (is_hlt)
   );

   // Next state plus the output values for the next cycle; outputs are then
   // registered so each beat lines up exactly with its state.
   always_comb begin
      state_nxt      = state;
      wait_nxt       = '0;
      waiting        = 1'b0;
      o_nxt          = '0;
      o_nxt.halted   = o.halted;
      o_nxt.bus_err  = o.bus_err;

      unique case (state)
         S_IDLE:   if (ready && (run || step)) state_nxt = S_FETCH;
         S_FETCH: begin
            if (mem_ack) begin
               state_nxt     = S_DECODE;
               o_nxt.ir_load = 1'b1;
               o_nxt.pc_inc  = 1'b1;
            end else begin
               waiting = 1'b1;
            end
         end
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC: begin
            if (is_load || is_store) begin
               state_nxt = S_MEM;
            end else if (is_hlt) begin
               state_nxt    = S_HALT;
               o_nxt.halted = 1'b1;
            end else begin
               state_nxt = S_WB;
            end
         end
         S_MEM: begin
            if (mem_ack) state_nxt = S_WB;
            else         waiting   = 1'b1;
         end
         S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_IDLE;
      endcase

      // A stalled bus transaction gives up after MEM_TIMEOUT silent cycles.
      if (waiting) begin
         if (wait_cnt == WAIT_LAST) begin
            state_nxt     = S_HALT;
            o_nxt.bus_err = 1'b1;
         end else begin
            wait_nxt = wait_cnt + CW'(1);
         end
      end

      o_nxt.t1      = (state_nxt == S_FETCH);
      o_nxt.t2      = (state_nxt == S_DECODE);
      o_nxt.t3      = (state_nxt == S_EXEC) || (state_nxt == S_MEM);
      o_nxt.t4      = (state_nxt == S_WB);
      o_nxt.mem_req = (state_nxt == S_FETCH) || (state_nxt == S_MEM);
      o_nxt.mem_we  = (state_nxt == S_MEM) && is_store;
      o_nxt.reg_we  = (state_nxt == S_WB) && (is_alu || is_load);
   end

   // 'ready' holds IDLE for one extra edge after reset release so the first
   // transition never races the deasserting reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         o        <= '0;
         ready    <= 1'b0;
      end else begin
         ready    <= 1'b1;
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         o        <= o_nxt;
      end
   end

   // Branch decision uses the zero flag live during EXEC.
   assign pc_load = (state == S_EXEC) && (is_jmp || (is_bz && zf));

   assign T1      = o.t1;
   assign T2      = o.t2;
   assign T3      = o.t3;
   assign T4      = o.t4;
   assign ir_load = o.ir_load;
   assign pc_inc  = o.pc_inc;
   assign mem_req = o.mem_req;
   assign mem_we  = o.mem_we;
   assign reg_we  = o.reg_we;
   assign halted  = o.halted;
   assign bus_err = o.bus_err;

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, is the max cycles to wait for mem_ack before flagging a bus error.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level; 1 = free-run, 0 = stop at next instruction boundary.
REQ-005 step  input  1  single-cycle pulse; executes exactly one instruction while run=0.
REQ-006 ir  input  16  instruction register contents, [15:11] opcode, [10:8] rd, [7:5] rs, [4:0] imm.
REQ-007 zf  input  1  zero flag from Execute, sampled in EXEC.
REQ-008 mem_ack  input  1  memory completion, valid while mem_req=1.
REQ-009 T1,T2,T3,T4  output  1 each  one-hot beat signals for FETCH, DECODE, EXEC, WB.
REQ-010 ir_load  output  1  load IR from memory data (pulse on fetch completion).
REQ-011 pc_inc  output  1  PC+1 pulse; pc_load  output  1  load PC from Addr (taken jump/branch).
REQ-012 mem_req  output  1  memory request; mem_we  output  1  write qualifier for mem_req.
REQ-013 reg_we  output  1  register-file write enable, WB only.
REQ-014 halted  output  1  HLT executed; bus_err  output  1  memory timeout, sticky.

Function
REQ-015 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; encoded state register, outputs registered.
REQ-016 IDLE -> FETCH when run=1 or step=1; otherwise stays IDLE with all beats 0.
REQ-017 FETCH: T1=1, mem_req=1, mem_we=0; on mem_ack: ir_load=1 and pc_inc=1 for one cycle, -> DECODE.
REQ-018 DECODE: T2=1 for exactly one cycle, -> EXEC.
REQ-019 EXEC: T3=1 for one cycle; LOAD/STORE -> MEM; HLT -> HALT; all other opcodes -> WB.
REQ-020 JMP in EXEC: pc_load=1; BZ in EXEC: pc_load=zf; both -> WB with reg_we=0.
REQ-021 MEM: T3 held, mem_req=1, mem_we=1 for STORE, 0 for LOAD; on mem_ack -> WB.
REQ-022 WB: T4=1 one cycle; reg_we=1 for ALU ops and LOAD, 0 for STORE/JMP/BZ/NOP.
REQ-023 After WB: run=1 -> FETCH; run=0 -> IDLE (step consumed).
REQ-024 mem_ack outside FETCH/MEM is ignored; mem_ack in the same cycle mem_req rises is accepted (zero-wait memory gives FETCH of 1 cycle).
REQ-025 Wait counter counts cycles in FETCH/MEM with mem_ack=0; reaching MEM_TIMEOUT sets bus_err, -> HALT.
REQ-026 HALT: halted=1 (or bus_err), all beats and strobes 0; exit only by reset.
REQ-027 run falling mid-instruction completes the instruction through WB, then IDLE; step while run=1 is ignored.
REQ-028 Exactly one of T1..T4 is high in FETCH..WB; none in IDLE/HALT; pc_inc and pc_load never both high.
REQ-029 Unknown opcode executes as NOP (WB with reg_we=0).

Reset
REQ-030 rst=0 forces IDLE asynchronously; T1..T4, ir_load, pc_inc, pc_load, mem_req, mem_we, reg_we, halted, bus_err = 0, wait counter = 0.
REQ-031 Reset during MEM or FETCH drops mem_req immediately; no strobe emitted on release.
REQ-032 Reset deasserts synchronously-safe: first state transition on the second rising edge after rst rises.

Structure
REQ-033 Shared package cpu_pkg holds opcode constants (OP_ADD 00000, OP_SUB 00001, OP_AND 00010, OP_OR 00011, OP_LOAD 01000, OP_STORE 01001, OP_JMP 01100, OP_BZ 01101, OP_NOP 11110, OP_HLT 11111) and the state encoding.
REQ-034 One sub-module, seq_decode, combinationally classifies the opcode into is_alu/is_load/is_store/is_jmp/is_bz/is_hlt; the FSM and wait counter stay in cpu_seq.

Verification
REQ-035 ADD (ir=00000_000_001_00000), run=1, mem_ack tied 1 -> T1,T2,T3,T4 on 4 consecutive cycles, reg_we=1 in T4 only, pc_inc once.
REQ-036 LOAD with mem_ack delayed 3 cycles in MEM -> T3 held 4 cycles, mem_we=0, reg_we=1 in following WB.
REQ-037 BZ with zf=1 then zf=0 -> pc_load=1 in first EXEC, 0 in second; reg_we=0 both.
REQ-038 run=0, step pulse -> exactly one T1..T4 sequence, then IDLE; second step -> one more.
REQ-039 mem_ack never asserted in FETCH -> bus_err=1 after 15 wait cycles, HALT, mem_req=0.
REQ-040 rst=0 asserted mid-MEM -> all outputs 0 same cycle; HLT opcode -> halted=1, beats stay 0 until reset.
